// File: rtl/io_reg_master_if.sv
// rtl/io_reg_master_if.sv - host command/response, responder strobe port and status bundle for io_reg_master
interface io_reg_master_if #(
    parameter int DEPTH = 4
) ();
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_we_i;
    logic [5:0]       cmd_reg_i;
    logic [7:0]       cmd_data_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [5:0]       rsp_reg_o;
    logic [7:0]       rsp_data_o;
    logic             update_t_o;
    logic [5:0]       wr_reg_o;
    logic [7:0]       wr_data_o;
    logic [5:0]       rd_reg_o;
    logic [7:0]       rd_data_i;
    logic [LVL_W-1:0] level_o;
    logic             busy_o;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_reg_i, cmd_data_i, rsp_ready_i, rd_data_i,
        output cmd_ready_o, rsp_valid_o, rsp_reg_o, rsp_data_o,
        output update_t_o, wr_reg_o, wr_data_o, rd_reg_o, level_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_reg_i, cmd_data_i, rsp_ready_i, rd_data_i,
        input  cmd_ready_o, rsp_valid_o, rsp_reg_o, rsp_data_o,
        input  update_t_o, wr_reg_o, wr_data_o, rd_reg_o, level_o, busy_o
    );
endinterface

// File: rtl/io_reg_master.sv
// rtl/io_reg_master.sv - queued write/read initiator for the toggle-strobe LED/switch register port
module io_reg_master #(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1,
    parameter int WR_GAP = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    io_reg_master_if.master   bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CNT_MAX = (RD_LAT > WR_GAP) ? RD_LAT : WR_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_RWAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [14:0]        mem_q [DEPTH];
    logic [14:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         cur_reg_q, cur_reg_d;
    logic [7:0]         cur_data_q, cur_data_d;
    logic               update_t_q, update_t_d;
    logic [5:0]         wr_reg_q, wr_reg_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic [5:0]         rd_reg_q, rd_reg_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [5:0]         rsp_reg_q, rsp_reg_d;
    logic [7:0]         rsp_data_q, rsp_data_d;

    logic [14:0] head;
    logic        push, pop;

    assign head = mem_q[rd_ptr_q];
    assign push = bus.cmd_valid_i && cmd_ready_q;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = head[14] ? S_WRITE : S_RWAIT;
            S_WRITE: state_d = S_GAP;
            S_GAP:   if (cnt_q == CNT_W'(WR_GAP - 1)) state_d = S_IDLE;
            S_RWAIT: if (cnt_q == CNT_W'(RD_LAT)) state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + LVL_W'(push) - LVL_W'(pop);
        cnt_d       = '0;
        cur_reg_d   = cur_reg_q;
        cur_data_d  = cur_data_q;
        update_t_d  = update_t_q;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        rd_reg_d    = rd_reg_q;
        rsp_valid_d = rsp_valid_q;
        rsp_reg_d   = rsp_reg_q;
        rsp_data_d  = rsp_data_q;

        if (push) begin
            mem_d[wr_ptr_q] = {bus.cmd_we_i, bus.cmd_reg_i, bus.cmd_data_i};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        // Ready is registered, so it must reflect the level after this edge's push/pop.
        cmd_ready_d = (count_d != LVL_W'(DEPTH));

        // The wait counter only runs while dwelling in GAP or RWAIT.
        if ((state_d == state_q) && (state_q == S_GAP || state_q == S_RWAIT)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    cur_reg_d  = head[13:8];
                    cur_data_d = head[7:0];
                    if (!head[14]) rd_reg_d = head[13:8];
                end
            end
            S_WRITE: begin
                wr_reg_d   = cur_reg_q;
                wr_data_d  = cur_data_q;
                update_t_d = ~update_t_q;
            end
            S_RWAIT: begin
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    rsp_valid_d = 1'b1;
                    rsp_reg_d   = cur_reg_q;
                    rsp_data_d  = bus.rd_data_i;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            cur_reg_q   <= '0;
            cur_data_q  <= '0;
            update_t_q  <= 1'b0;
            wr_reg_q    <= 6'h3F;
            wr_data_q   <= '0;
            rd_reg_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_reg_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            cnt_q       <= cnt_d;
            cur_reg_q   <= cur_reg_d;
            cur_data_q  <= cur_data_d;
            update_t_q  <= update_t_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            rd_reg_q    <= rd_reg_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_reg_q   <= rsp_reg_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.update_t_o  = update_t_q;
    assign bus.wr_reg_o    = wr_reg_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.rd_reg_o    = rd_reg_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_reg_o   = rsp_reg_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.level_o     = count_q;
    assign bus.busy_o      = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_io_reg_master.sv
// tb/tb_io_reg_master.sv - directed bench for io_reg_master with a toggle-strobe responder model
module tb_io_reg_master;
    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    io_reg_master_if #(.DEPTH(4)) bus ();

    io_reg_master #(.DEPTH(4), .RD_LAT(1), .WR_GAP(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Responder: commits one write per level change of update_t, registered read data.
    // Addresses below 16 read back switch bits as 00/FF; 6'h3F is unmapped.
    logic        resp_t    = 1'b0;
    logic        resp_init = 1'b0;
    logic [15:0] sw        = 16'h0008;
    logic [7:0]  resp_regs [64];

    always @(posedge clk) begin
        if (!resp_init) begin
            for (int i = 0; i < 64; i++) resp_regs[i] <= 8'h00;
            resp_init <= 1'b1;
        end else if (bus.update_t_o != resp_t) begin
            resp_t <= bus.update_t_o;
            if (bus.wr_reg_o != 6'h3F) resp_regs[bus.wr_reg_o] <= bus.wr_data_o;
        end
        bus.rd_data_i <= (bus.rd_reg_o < 6'd16) ? (sw[bus.rd_reg_o[3:0]] ? 8'hFF : 8'h00)
                                                : resp_regs[bus.rd_reg_o];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [5:0] r, input logic [7:0] d);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_reg_i   = r;
        bus.cmd_data_i  = d;
    endtask

    task automatic idle_cmd();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_reg_i   = 6'h00;
        bus.cmd_data_i  = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready_o, 0);
        check({tag, "_update_t"},  bus.update_t_o, 0);
        check({tag, "_wr_reg"},    bus.wr_reg_o, 6'h3F);
        check({tag, "_wr_data"},   bus.wr_data_o, 0);
        check({tag, "_rd_reg"},    bus.rd_reg_o, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
        check({tag, "_rsp_reg"},   bus.rsp_reg_o, 0);
        check({tag, "_rsp_data"},  bus.rsp_data_o, 0);
        check({tag, "_level"},     bus.level_o, 0);
        check({tag, "_busy"},      bus.busy_o, 0);
    endtask

    initial begin
        int   t1, t2, ntog;
        logic prev_t;

        reset_n         = 1'b0;
        bus.rsp_ready_i = 1'b0;
        idle_cmd();
        tick();
        tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        check("ready_before_edge", bus.cmd_ready_o, 0);
        tick();
        check("ready_after_edge", bus.cmd_ready_o, 1);

        // Single write 05 <= 01: toggle one edge after the pop.
        drive(1'b1, 6'h05, 8'h01);
        tick();
        idle_cmd();
        check("w1_level_push", bus.level_o, 1);
        check("w1_busy", bus.busy_o, 1);
        tick();
        check("w1_level_pop", bus.level_o, 0);
        check("w1_no_toggle_yet", bus.update_t_o, 0);
        tick();
        check("w1_toggle", bus.update_t_o, 1);
        check("w1_wr_reg", bus.wr_reg_o, 6'h05);
        check("w1_wr_data", bus.wr_data_o, 8'h01);
        tick();
        check("w1_led5", resp_regs[5], 8'h01);
        check("w1_idle", bus.busy_o, 0);

        // Write 10 <= E3, then read 03 with sw[3]=1.
        drive(1'b1, 6'h10, 8'hE3);
        tick();
        drive(1'b0, 6'h03, 8'h00);
        tick();
        idle_cmd();
        tick();
        check("w2_toggle", bus.update_t_o, 0);
        check("w2_wr_reg", bus.wr_reg_o, 6'h10);
        check("w2_wr_data", bus.wr_data_o, 8'hE3);
        tick();
        tick();
        check("r1_rd_reg", bus.rd_reg_o, 6'h03);
        check("r1_valid_early0", bus.rsp_valid_o, 0);
        tick();
        check("r1_valid_early1", bus.rsp_valid_o, 0);
        tick();
        check("r1_valid", bus.rsp_valid_o, 1);
        check("r1_data", bus.rsp_data_o, 8'hFF);
        check("r1_reg", bus.rsp_reg_o, 6'h03);
        check("w2_reg10", resp_regs[6'h10], 8'hE3);

        // Fill the FIFO while the response is stalled.
        drive(1'b1, 6'h11, 8'h5A);
        tick();
        drive(1'b0, 6'h11, 8'h00);
        tick();
        drive(1'b1, 6'h07, 8'h01);
        tick();
        drive(1'b1, 6'h08, 8'h01);
        tick();
        check("full_level", bus.level_o, 4);
        check("full_ready", bus.cmd_ready_o, 0);
        drive(1'b1, 6'h09, 8'h01);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_ready", bus.cmd_ready_o, 0);
            check("stall_level", bus.level_o, 4);
            check("stall_valid", bus.rsp_valid_o, 1);
            check("stall_data", bus.rsp_data_o, 8'hFF);
            check("stall_update_t", bus.update_t_o, 0);
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check("rsp_cleared", bus.rsp_valid_o, 0);
        check("rsp_clr_level", bus.level_o, 4);
        tick();
        check("pop_level", bus.level_o, 3);
        check("pop_ready", bus.cmd_ready_o, 1);
        tick();
        idle_cmd();
        check("fifth_level", bus.level_o, 4);
        check("fifth_ready", bus.cmd_ready_o, 0);
        check("w11_toggle", bus.update_t_o, 1);
        check("w11_wr_reg", bus.wr_reg_o, 6'h11);
        check("w11_wr_data", bus.wr_data_o, 8'h5A);
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid_o) break;
            tick();
        end
        check("r2_valid", bus.rsp_valid_o, 1);
        check("r2_data_order", bus.rsp_data_o, 8'h5A);
        check("r2_reg", bus.rsp_reg_o, 6'h11);
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy_o) break;
            tick();
        end
        tick();
        check("drain_busy", bus.busy_o, 0);
        check("led7", resp_regs[7], 8'h01);
        check("led8", resp_regs[8], 8'h01);
        check("led9", resp_regs[9], 8'h01);

        // Back-to-back writes: toggles spaced 2+WR_GAP cycles.
        drive(1'b1, 6'h0A, 8'h01);
        tick();
        drive(1'b1, 6'h0B, 8'h01);
        tick();
        idle_cmd();
        prev_t = bus.update_t_o;
        t1 = -1;
        t2 = -1;
        ntog = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.update_t_o !== prev_t) begin
                if (ntog == 0) t1 = i;
                else t2 = i;
                ntog++;
                prev_t = bus.update_t_o;
            end
        end
        check("b2b_toggles", ntog, 2);
        check("b2b_spacing", t2 - t1, 3);
        check("b2b_ledA", resp_regs[6'h0A], 8'h01);
        check("b2b_ledB", resp_regs[6'h0B], 8'h01);

        // Reset right after a toggle to 1, with another write still queued.
        drive(1'b1, 6'h0C, 8'h01);
        tick();
        drive(1'b1, 6'h0D, 8'h01);
        tick();
        idle_cmd();
        tick();
        check("pre_rst_toggle", bus.update_t_o, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", bus.cmd_ready_o, 1);
        for (int i = 0; i < 6; i++) tick();
        check("post_rst_ledC", resp_regs[6'h0C], 8'h00);
        check("post_rst_ledD", resp_regs[6'h0D], 8'h00);
        check("post_rst_led5", resp_regs[5], 8'h01);
        check("post_rst_update_t", bus.update_t_o, 0);
        check("post_rst_busy", bus.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
